// File: rtl/mioc_dram_pkg.sv
// Shared types and constants for the MIOC DRAM access sequencer.
package mioc_dram_pkg;

    // Cycles without any refresh before a self refresh is inserted.
    localparam int REF_TIMEOUT_DEF = 48;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW,
        ST_COL,
        ST_CAS,
        ST_REF,
        ST_SREF1,
        ST_SREF2,
        ST_PRE
    } state_t;

    // Which requester owns the current ROW/COL/CAS/PRE cycle.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_Z80,
        OWN_DMA
    } owner_t;

    // Source of the multiplexed RA7 address bit.
    typedef enum logic [1:0] {
        RA7_SRC_ROW,   // BA7 while the row address is presented
        RA7_SRC_COL,   // BA14 while the column address is presented
        RA7_SRC_REF    // refresh row counter MSB during any refresh
    } ra7_src_t;

    function automatic ra7_src_t ra7_src(input state_t st, input logic mux);
        ra7_src_t src;
        if (st inside {ST_REF, ST_SREF1, ST_SREF2}) begin
            src = RA7_SRC_REF;
        end else if (mux) begin
            src = RA7_SRC_COL;
        end else begin
            src = RA7_SRC_ROW;
        end
        return src;
    endfunction

endpackage

// File: rtl/mioc_ref_counter.sv
// Refresh row counter and saturating refresh-timeout counter.
// ref_done is a one-cycle strobe issued while PRE follows a completed refresh;
// on that edge the row counter advances and the timeout restarts from zero.
module mioc_ref_counter
    import mioc_dram_pkg::*;
#(
    parameter int REF_TIMEOUT = REF_TIMEOUT_DEF
) (
    input  logic       B_PHI,
    input  logic       RESET,
    input  logic       ref_done,
    output logic [7:0] ref_cnt,
    output logic       timeout
);

    localparam int              TW      = $clog2(REF_TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_MAX = TW'(REF_TIMEOUT);

    logic [7:0]    ref_cnt_d, ref_cnt_q;
    logic [TW-1:0] tmo_d, tmo_q;

    // Advance row counter on a completed refresh; otherwise let the timeout saturate upward.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        ref_cnt_d = ref_cnt_q;
        tmo_d     = tmo_q;
        if (ref_done) begin
            ref_cnt_d = ref_cnt_q + 8'd1;
            tmo_d     = '0;
        end else if (tmo_q < TMO_MAX) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge B_PHI) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (RESET) begin
            ref_cnt_q <= '0;
            tmo_q     <= '0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign ref_cnt = ref_cnt_q;
    assign timeout = (tmo_q == TMO_MAX);

endmodule

// File: rtl/mioc_dram_seq.sv
// DRAM access sequencer and arbiter: shares the 64K DRAM between Z80 memory
// cycles, Z80 refresh cycles and 6801 DMA, and inserts a self refresh when
// the Z80 has not refreshed for REF_TIMEOUT cycles. All outputs are registered
// from the next-state value so strobes change exactly on the state edge.
module mioc_dram_seq
    import mioc_dram_pkg::*;
#(
    parameter int REF_TIMEOUT = REF_TIMEOUT_DEF
) (
    input  logic       B_PHI,
    input  logic       RESET,
    input  logic       BMREQ_N,
    input  logic       BRFSH_N,
    input  logic       BRD_N,
    input  logic       N_BWR,
    input  logic       DMA_N,
    input  logic       RAM_EN,
    input  logic       BA15,
    input  logic       BA14,
    input  logic       BA7,
    output logic       RAS_N,
    output logic       MUX,
    output logic       CAS1_N,
    output logic       CAS2_N,
    output logic       RA7,
    output logic       EN245_N,
    output logic       DMA_GNT,
    output logic [7:0] REF_CNT
);

    state_t state_d, state_q;
    owner_t owner_d, owner_q;
    logic   bank_d, bank_q;
    logic   ref_done_d, ref_done_q;

    logic   ras_n_d, ras_n_q;
    logic   mux_d, mux_q;
    logic   cas1_n_d, cas1_n_q;
    logic   cas2_n_d, cas2_n_q;
    logic   ra7_d, ra7_q;
    logic   en245_n_d, en245_n_q;
    logic   dma_gnt_d, dma_gnt_q;

    logic   ref_req, z80_req, dma_req, owner_active;
    logic   timeout;
    logic [7:0] ref_cnt;

    mioc_ref_counter #(
        .REF_TIMEOUT (REF_TIMEOUT)
    ) u_ref_counter (
        .B_PHI    (B_PHI),
        .RESET    (RESET),
        .ref_done (ref_done_q),
        .ref_cnt  (ref_cnt),
        .timeout  (timeout)
    );

    assign ref_req      = !BMREQ_N && !BRFSH_N;
    assign z80_req      = !BMREQ_N && BRFSH_N && RAM_EN;
    assign dma_req      = !DMA_N;
    assign owner_active = (owner_q == OWN_DMA) ? !DMA_N : !BMREQ_N;

    // Arbitration (IDLE only, no preemption) and state sequencing.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        bank_d  = bank_q;
        unique case (state_q)
            ST_IDLE: begin
                owner_d = OWN_NONE;
                if (ref_req) begin
                    state_d = ST_REF;
                end else if (z80_req) begin
                    state_d = ST_ROW;
                    owner_d = OWN_Z80;
                    bank_d  = BA15;
                end else if (dma_req) begin
                    state_d = ST_ROW;
                    owner_d = OWN_DMA;
                    bank_d  = BA15;
                end else if (timeout) begin
                    state_d = ST_SREF1;
                end
            end
            ST_ROW:   state_d = ST_COL;
            ST_COL:   state_d = ST_CAS;
            ST_CAS:   if (!owner_active) state_d = ST_PRE;
            ST_REF:   if (BMREQ_N) state_d = ST_PRE;
            ST_SREF1: state_d = ST_SREF2;
            ST_SREF2: state_d = ST_PRE;
            ST_PRE:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // A refresh counts as complete once its PRE is reached.
        ref_done_d = (state_q inside {ST_REF, ST_SREF2}) && (state_d == ST_PRE);
    end

    // Output values for the state being entered on this edge.
    always_comb begin
        ras_n_d   = !(state_d inside {ST_ROW, ST_COL, ST_CAS, ST_REF, ST_SREF1, ST_SREF2});
        mux_d     = state_d inside {ST_COL, ST_CAS};
        cas1_n_d  = !((state_d == ST_CAS) && !bank_d);
        cas2_n_d  = !((state_d == ST_CAS) && bank_d);
        en245_n_d = !((state_d == ST_CAS) && (owner_d == OWN_Z80) && (!BRD_N || !N_BWR));
        dma_gnt_d = (owner_d == OWN_DMA) && (state_d != ST_IDLE);
        unique case (ra7_src(state_d, mux_d))
            RA7_SRC_REF: ra7_d = ref_cnt[7];
            RA7_SRC_COL: ra7_d = BA14;
            default:     ra7_d = BA7;
        endcase
    end

    // State and output registers; reset abandons any in-flight cycle.
    always_ff @(posedge B_PHI) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_NONE;
            bank_q     <= 1'b0;
            ref_done_q <= 1'b0;
            ras_n_q    <= 1'b1;
            mux_q      <= 1'b0;
            cas1_n_q   <= 1'b1;
            cas2_n_q   <= 1'b1;
            ra7_q      <= 1'b0;
            en245_n_q  <= 1'b1;
            dma_gnt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            bank_q     <= bank_d;
            ref_done_q <= ref_done_d;
            ras_n_q    <= ras_n_d;
            mux_q      <= mux_d;
            cas1_n_q   <= cas1_n_d;
            cas2_n_q   <= cas2_n_d;
            ra7_q      <= ra7_d;
            en245_n_q  <= en245_n_d;
            dma_gnt_q  <= dma_gnt_d;
        end
    end

    assign RAS_N   = ras_n_q;
    assign MUX     = mux_q;
    assign CAS1_N  = cas1_n_q;
    assign CAS2_N  = cas2_n_q;
    assign RA7     = ra7_q;
    assign EN245_N = en245_n_q;
    assign DMA_GNT = dma_gnt_q;
    assign REF_CNT = ref_cnt;

endmodule

// File: tb/tb_mioc_dram_seq.sv
// Self-checking bench for mioc_dram_seq: per-cycle expected outputs are queued
// as stimulus is driven and compared once the edge has produced the outputs.
module tb_mioc_dram_seq;

    logic       B_PHI = 1'b0;
    logic       RESET = 1'b1;
    logic       BMREQ_N = 1'b1, BRFSH_N = 1'b1, BRD_N = 1'b1, N_BWR = 1'b1;
    logic       DMA_N = 1'b1, RAM_EN = 1'b0, BA15 = 1'b0, BA14 = 1'b0, BA7 = 1'b0;
    logic       RAS_N, MUX, CAS1_N, CAS2_N, RA7, EN245_N, DMA_GNT;
    logic [7:0] REF_CNT;

    mioc_dram_seq #(.REF_TIMEOUT(48)) dut (
        .B_PHI   (B_PHI),
        .RESET   (RESET),
        .BMREQ_N (BMREQ_N),
        .BRFSH_N (BRFSH_N),
        .BRD_N   (BRD_N),
        .N_BWR   (N_BWR),
        .DMA_N   (DMA_N),
        .RAM_EN  (RAM_EN),
        .BA15    (BA15),
        .BA14    (BA14),
        .BA7     (BA7),
        .RAS_N   (RAS_N),
        .MUX     (MUX),
        .CAS1_N  (CAS1_N),
        .CAS2_N  (CAS2_N),
        .RA7     (RA7),
        .EN245_N (EN245_N),
        .DMA_GNT (DMA_GNT),
        .REF_CNT (REF_CNT)
    );

    always #5 B_PHI = ~B_PHI;

    typedef struct packed {
        logic       ras_n, mux, cas1_n, cas2_n, ra7, en245_n, dma_gnt;
        logic [7:0] ref_cnt;
    } out_t;

    typedef struct packed {
        logic rst, mreq_n, rfsh_n, rd_n, wr_n, dma_n, ram_en, ba15, ba14, ba7;
    } stim_t;

    out_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    function automatic out_t mk(input logic ras_n, mux, c1, c2, ra7, en, gnt,
                                input logic [7:0] cnt);
        out_t o;
        o.ras_n = ras_n; o.mux = mux; o.cas1_n = c1; o.cas2_n = c2;
        o.ra7 = ra7; o.en245_n = en; o.dma_gnt = gnt; o.ref_cnt = cnt;
        return o;
    endfunction

    function automatic out_t idle_out(input logic [7:0] cnt);
        return mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, cnt);
    endfunction

    function automatic stim_t sv(input logic rst, mreq_n, rfsh_n, rd_n, wr_n,
                                 dma_n, ram_en, ba15, ba14, ba7);
        stim_t s;
        s.rst = rst; s.mreq_n = mreq_n; s.rfsh_n = rfsh_n; s.rd_n = rd_n;
        s.wr_n = wr_n; s.dma_n = dma_n; s.ram_en = ram_en; s.ba15 = ba15;
        s.ba14 = ba14; s.ba7 = ba7;
        return s;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.ras_n = RAS_N; o.mux = MUX; o.cas1_n = CAS1_N; o.cas2_n = CAS2_N;
        o.ra7 = RA7; o.en245_n = EN245_N; o.dma_gnt = DMA_GNT; o.ref_cnt = REF_CNT;
        return o;
    endfunction

    task automatic apply(input stim_t s);
        RESET = s.rst; BMREQ_N = s.mreq_n; BRFSH_N = s.rfsh_n; BRD_N = s.rd_n;
        N_BWR = s.wr_n; DMA_N = s.dma_n; RAM_EN = s.ram_en; BA15 = s.ba15;
        BA14 = s.ba14; BA7 = s.ba7;
    endtask

    task automatic tick();
        @(posedge B_PHI);
        #1;
    endtask

    task automatic do_reset();
        apply(sv(1, 1, 1, 1, 1, 1, 0, 0, 0, 0));
        tick();
        tick();
        apply(sv(0, 1, 1, 1, 1, 1, 0, 0, 0, 0));
    endtask

    // Refresh to make REF_CNT nonzero, start a read, then reset three cycles mid-CAS.
    task automatic test_reset();
        stim_t st[$];
        out_t  ex[$];
        out_t  g_o, e_o;
        stim_t s_idle = sv(0, 1, 1, 1, 1, 1, 0, 0, 0, 0);
        stim_t s_rd   = sv(0, 0, 1, 0, 1, 1, 1, 0, 0, 0);
        do_reset();
        st.push_back(sv(0, 0, 0, 1, 1, 1, 0, 0, 0, 0)); ex.push_back(mk(0, 0, 1, 1, 0, 1, 0, 8'd0));
        st.push_back(s_idle); ex.push_back(idle_out(8'd0));
        st.push_back(s_idle); ex.push_back(idle_out(8'd1));
        st.push_back(s_rd);   ex.push_back(mk(0, 0, 1, 1, 0, 1, 0, 8'd1));
        st.push_back(s_rd);   ex.push_back(mk(0, 1, 1, 1, 0, 1, 0, 8'd1));
        st.push_back(s_rd);   ex.push_back(mk(0, 1, 0, 1, 0, 0, 0, 8'd1));
        for (int k = 0; k < 3; k++) begin
            st.push_back(sv(1, 0, 1, 0, 1, 1, 1, 0, 0, 0)); ex.push_back(idle_out(8'd0));
        end
        st.push_back(s_idle); ex.push_back(idle_out(8'd0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            tick();
            g_o = sample();
            e_o = exp_q.pop_front();
            n_cmp++;
            if (g_o !== e_o) begin
                n_mis++;
                $display("FAIL reset[%0d]: got %b expected %b", i, g_o, e_o);
            end
        end
    endtask

    // Z80 read to the upper bank (held 4 cycles) and a minimum-length write to the lower bank.
    task automatic test_z80_access();
        stim_t st[$];
        out_t  ex[$];
        out_t  g_o, e_o;
        do_reset();
        for (int k = 0; k < 4; k++) st.push_back(sv(0, 0, 1, 0, 1, 1, 1, 1, 0, 1));
        ex.push_back(mk(0, 0, 1, 1, 1, 1, 0, 8'd0));
        ex.push_back(mk(0, 1, 1, 1, 0, 1, 0, 8'd0));
        ex.push_back(mk(0, 1, 1, 0, 0, 0, 0, 8'd0));
        ex.push_back(mk(0, 1, 1, 0, 0, 0, 0, 8'd0));
        st.push_back(sv(0, 1, 1, 1, 1, 1, 0, 1, 0, 1)); ex.push_back(mk(1, 0, 1, 1, 1, 1, 0, 8'd0));
        st.push_back(sv(0, 1, 1, 1, 1, 1, 0, 1, 0, 1)); ex.push_back(mk(1, 0, 1, 1, 1, 1, 0, 8'd0));
        for (int k = 0; k < 3; k++) st.push_back(sv(0, 0, 1, 1, 0, 1, 1, 0, 1, 0));
        ex.push_back(mk(0, 0, 1, 1, 0, 1, 0, 8'd0));
        ex.push_back(mk(0, 1, 1, 1, 1, 1, 0, 8'd0));
        ex.push_back(mk(0, 1, 0, 1, 1, 0, 0, 8'd0));
        st.push_back(sv(0, 1, 1, 1, 1, 1, 0, 0, 0, 0)); ex.push_back(idle_out(8'd0));
        st.push_back(sv(0, 1, 1, 1, 1, 1, 0, 0, 0, 0)); ex.push_back(idle_out(8'd0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            tick();
            g_o = sample();
            e_o = exp_q.pop_front();
            n_cmp++;
            if (g_o !== e_o) begin
                n_mis++;
                $display("FAIL z80_access[%0d]: got %b expected %b", i, g_o, e_o);
            end
        end
    endtask

    // Memory request outside DRAM: no strobes, stays idle.
    task automatic test_no_access();
        out_t g_o, e_o;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(sv(0, 0, 1, 0, 1, 1, 0, 1, 0, 0));
            exp_q.push_back(idle_out(8'd0));
            tick();
            g_o = sample();
            e_o = exp_q.pop_front();
            n_cmp++;
            if (g_o !== e_o) begin
                n_mis++;
                $display("FAIL no_access[%0d]: got %b expected %b", i, g_o, e_o);
            end
        end
        apply(sv(0, 1, 1, 1, 1, 1, 0, 0, 0, 0));
    endtask

    // 256 M1 + refresh pairs: REF_CNT wraps and RA7 tracks its MSB during refresh.
    task automatic test_refresh_wrap();
        stim_t st[$];
        out_t  ex[$];
        out_t  g_o, e_o;
        stim_t s_idle = sv(0, 1, 1, 1, 1, 1, 0, 0, 0, 0);
        stim_t s_m1   = sv(0, 0, 1, 0, 1, 1, 1, 0, 0, 0);
        stim_t s_ref  = sv(0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        logic [7:0] c;
        do_reset();
        for (int k = 0; k < 256; k++) begin
            c = k[7:0];
            st.push_back(s_m1);   ex.push_back(mk(0, 0, 1, 1, 0, 1, 0, c));
            st.push_back(s_m1);   ex.push_back(mk(0, 1, 1, 1, 0, 1, 0, c));
            st.push_back(s_m1);   ex.push_back(mk(0, 1, 0, 1, 0, 0, 0, c));
            st.push_back(s_idle); ex.push_back(idle_out(c));
            st.push_back(s_idle); ex.push_back(idle_out(c));
            st.push_back(s_ref);  ex.push_back(mk(0, 0, 1, 1, c[7], 1, 0, c));
            st.push_back(s_ref);  ex.push_back(mk(0, 0, 1, 1, c[7], 1, 0, c));
            st.push_back(s_idle); ex.push_back(idle_out(c));
            st.push_back(s_idle); ex.push_back(idle_out(c + 8'd1));
        end
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            tick();
            g_o = sample();
            e_o = exp_q.pop_front();
            n_cmp++;
            if (g_o !== e_o) begin
                n_mis++;
                $display("FAIL refresh_wrap[%0d]: got %b expected %b", i, g_o, e_o);
            end
        end
    endtask

    // Refresh and DMA together: refresh first, DMA granted after, EN245_N stays high for DMA.
    task automatic test_ref_vs_dma();
        stim_t st[$];
        out_t  ex[$];
        out_t  g_o, e_o;
        stim_t s_dma = sv(0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        do_reset();
        st.push_back(sv(0, 0, 0, 1, 1, 0, 0, 0, 0, 0)); ex.push_back(mk(0, 0, 1, 1, 0, 1, 0, 8'd0));
        st.push_back(sv(0, 0, 0, 1, 1, 0, 0, 0, 0, 0)); ex.push_back(mk(0, 0, 1, 1, 0, 1, 0, 8'd0));
        st.push_back(s_dma); ex.push_back(idle_out(8'd0));
        st.push_back(s_dma); ex.push_back(idle_out(8'd1));
        st.push_back(s_dma); ex.push_back(mk(0, 0, 1, 1, 0, 1, 1, 8'd1));
        st.push_back(s_dma); ex.push_back(mk(0, 1, 1, 1, 0, 1, 1, 8'd1));
        for (int k = 0; k < 3; k++) begin
            st.push_back(s_dma); ex.push_back(mk(0, 1, 0, 1, 0, 1, 1, 8'd1));
        end
        st.push_back(sv(0, 1, 1, 1, 1, 1, 0, 0, 0, 0)); ex.push_back(mk(1, 0, 1, 1, 0, 1, 1, 8'd1));
        st.push_back(sv(0, 1, 1, 1, 1, 1, 0, 0, 0, 0)); ex.push_back(idle_out(8'd1));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            tick();
            g_o = sample();
            e_o = exp_q.pop_front();
            n_cmp++;
            if (g_o !== e_o) begin
                n_mis++;
                $display("FAIL ref_vs_dma[%0d]: got %b expected %b", i, g_o, e_o);
            end
        end
    endtask

    // Long DMA starves refresh: self refresh follows the DMA, then the timeout restarts from zero.
    task automatic test_timeout();
        stim_t st[$];
        out_t  ex[$];
        out_t  g_o, e_o;
        stim_t s_dma  = sv(0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        stim_t s_idle = sv(0, 1, 1, 1, 1, 1, 0, 0, 0, 0);
        int    cycles;
        do_reset();
        st.push_back(s_dma); ex.push_back(mk(0, 0, 1, 1, 0, 1, 1, 8'd0));
        st.push_back(s_dma); ex.push_back(mk(0, 1, 1, 1, 0, 1, 1, 8'd0));
        for (int k = 0; k < 58; k++) begin
            st.push_back(s_dma); ex.push_back(mk(0, 1, 0, 1, 0, 1, 1, 8'd0));
        end
        st.push_back(s_idle); ex.push_back(mk(1, 0, 1, 1, 0, 1, 1, 8'd0));
        st.push_back(s_idle); ex.push_back(idle_out(8'd0));
        st.push_back(s_idle); ex.push_back(mk(0, 0, 1, 1, 0, 1, 0, 8'd0));
        st.push_back(s_idle); ex.push_back(mk(0, 0, 1, 1, 0, 1, 0, 8'd0));
        st.push_back(s_idle); ex.push_back(idle_out(8'd0));
        st.push_back(s_idle); ex.push_back(idle_out(8'd1));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            tick();
            g_o = sample();
            e_o = exp_q.pop_front();
            n_cmp++;
            if (g_o !== e_o) begin
                n_mis++;
                $display("FAIL timeout[%0d]: got %b expected %b", i, g_o, e_o);
            end
        end
        // Cleared counter needs 48 increments, then one IDLE edge to start SREF1.
        cycles = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            cycles++;
            if (RAS_N == 1'b0) break;
        end
        n_cmp++;
        if (cycles != 49 || RAS_N !== 1'b0) begin
            n_mis++;
            $display("FAIL timeout_restart: cycles to next self refresh %0d (RAS_N=%b), required 49", cycles, RAS_N);
        end
    endtask

    initial begin
        test_reset();
        test_z80_access();
        test_no_access();
        test_refresh_wrap();
        test_ref_vs_dma();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
